// File: rtl/if_stage.sv
// Instruction fetch: direct-mapped one-word-line cache in registers, refilled
// byte by byte from the memory controller on a miss.
module if_stage #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump_flag,
  output logic              if_mem_req,
  output logic [ADDR_W-1:0] if_mem_addr,
  input  logic              mem_if_busy,
  input  logic              mem_if_valid,
  input  logic [7:0]        mem_if_data,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall_req,
  output logic [1:0]        dbg_state
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int LINES = 1 << IDX_W;

  // Memory handshake: a byte request is accepted in any cycle with
  // if_mem_req=1 and mem_if_busy=0; its byte returns with mem_if_valid exactly
  // one cycle later. if_mem_addr is meaningful only while if_mem_req=1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              out_q, out_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [23:0]       byte_buf_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, got, fill, req, accepted;
  logic [1:0]        req_k;
  logic              pc_unused;

  assign idx       = pc[IDX_W+1:2];
  assign tag       = pc[ADDR_W-1:IDX_W+2];
  assign fill_idx  = miss_addr_q[IDX_W+1:2];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign got       = (state_q == S_FETCH) && out_q && mem_if_valid;
  assign fill      = got && (k_q == 2'd3);
  assign pc_unused = ^pc[1:0];
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_d       = out_q;
    miss_addr_d = miss_addr_q;
    req         = 1'b0;
    req_k       = k_q;
    accepted    = 1'b0;
    if_mem_addr = '0;
    inst        = '0;
    inst_pc     = '0;
    inst_valid  = 1'b0;
    stall_req   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!jump_flag) begin
          if (hit) begin
            inst       = data_q[idx];
            inst_pc    = pc;
            inst_valid = 1'b1;
          end else begin
            stall_req   = 1'b1;
            req         = 1'b1;
            if_mem_addr = pc;
            accepted    = !mem_if_busy;
            miss_addr_d = pc;
            k_d         = 2'd0;
            out_d       = accepted;
            state_d     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        stall_req = !jump_flag;
        // The next byte is requested in the same cycle the previous one lands.
        req   = !out_q || (got && (k_q != 2'd3));
        req_k = out_q ? k_q + 2'd1 : k_q;
        if (req) if_mem_addr = miss_addr_q + ADDR_W'(req_k);
        accepted = req && !mem_if_busy;
        if (got) k_d = k_q + 2'd1;
        if (accepted) out_d = 1'b1;
        else if (got) out_d = 1'b0;
        if (fill) state_d = S_IDLE;
        if (jump_flag) begin
          // A byte still in flight must be swallowed before a new miss starts.
          k_d     = 2'd0;
          out_d   = 1'b0;
          state_d = (accepted || (out_q && !mem_if_valid)) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (mem_if_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if_mem_req = req;
    if (rst) begin
      if_mem_req  = 1'b0;
      if_mem_addr = '0;
      inst        = '0;
      inst_pc     = '0;
      inst_valid  = 1'b0;
      stall_req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      out_q       <= 1'b0;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_q       <= out_d;
      miss_addr_q <= miss_addr_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Byte 3 goes straight into the line, so only bytes 0..2 are buffered.
  always_ff @(posedge clk) begin
    if (got) begin
      case (k_q)
        2'd0:    byte_buf_q[7:0]   <= mem_if_data;
        2'd1:    byte_buf_q[15:8]  <= mem_if_data;
        2'd2:    byte_buf_q[23:16] <= mem_if_data;
        default: ;
      endcase
    end
    if (fill) begin
      tag_q[fill_idx]  <= miss_addr_q[ADDR_W-1:IDX_W+2];
      data_q[fill_idx] <= {mem_if_data, byte_buf_q};
    end
  end
endmodule
